main_mem_responder: RTL
=======================

MAIN_MEM_RESPONDER -- requirements
Module: main_mem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 4: cycles from request accept to the first response beat; legal range 1..15.
REQ-002 SHALL have parameter LINE_WORDS, default 16: 32-bit words per cache line (64-byte line).
REQ-003 SHALL have parameter MEM_WORDS, default 1024: backing-store depth in 32-bit words (4 KB); power of two.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 mem_req_valid  input  1  initiator (cache miss/write path) presents a request.
REQ-007 mem_req_ready  output  1  responder can accept a request this cycle.
REQ-008 mem_req_write  input  1  1 = single-word write; 0 = line read (refill).
REQ-009 mem_req_addr  input  32  byte address.
REQ-010 mem_req_wdata  input  32  write data; ignored for reads.
REQ-011 mem_rsp_valid  output  1  response beat present.
REQ-012 mem_rsp_ready  input  1  initiator accepts the beat this cycle.
REQ-013 mem_rsp_data  output  32  read word, or echoed write data for a write ack.
REQ-014 mem_rsp_last  output  1  final beat of the response.
REQ-015 mem_rsp_is_write  output  1  beat is a write acknowledge.

Function
REQ-016 Word index SHALL be mem_req_addr[log2(MEM_WORDS)+1:2]; bits [1:0] and all higher bits SHALL be ignored, so addresses alias modulo MEM_WORDS*4.
REQ-017 FSM states SHALL be IDLE, WAIT, BURST and WACK; mem_req_ready SHALL be 1 only in IDLE.
REQ-018 A request is accepted on a rising edge with mem_req_valid and mem_req_ready both 1; the address, type and data SHALL be captured on that edge.
REQ-019 An accepted write SHALL update the word on the accept edge; IDLE->WAIT.
REQ-020 An accepted read SHALL latch base word = index with the low log2(LINE_WORDS) bits cleared (line-aligned); IDLE->WAIT.
REQ-021 WAIT SHALL count LATENCY-1 further cycles, so mem_rsp_valid first rises exactly LATENCY cycles after the accept edge; it then moves to BURST (read) or WACK (write).
REQ-022 BURST SHALL return LINE_WORDS beats, base word first, ascending index, no critical-word-first reordering; mem_rsp_last=1 only on the final beat.
REQ-023 WACK SHALL present one beat: mem_rsp_is_write=1, mem_rsp_last=1, mem_rsp_data = captured write data.
REQ-024 A beat SHALL complete only on an edge with mem_rsp_valid and mem_rsp_ready both 1; while mem_rsp_ready=0, mem_rsp_data/last/is_write SHALL hold stable and no beat is dropped or repeated.
REQ-025 With mem_rsp_ready held at 1, the beats SHALL be back-to-back, one per cycle.
REQ-026 After the last beat completes, the FSM SHALL return to IDLE, with mem_req_ready=1 on the next cycle; back-to-back requests are thus not pipelined.
REQ-027 Read data SHALL reflect every write accepted before the read's accept edge, including a write accepted on the immediately preceding edge.
REQ-028 Outside BURST/WACK, mem_rsp_valid, mem_rsp_last and mem_rsp_is_write SHALL be 0 and mem_rsp_data SHALL be 0.
REQ-029 mem_req_valid SHALL be ignored outside IDLE; a request held across a busy period is accepted on the first IDLE cycle.

Reset
REQ-030 On a reset edge, the FSM SHALL go to IDLE and the counters SHALL clear; next cycle mem_req_ready=1, mem_rsp_valid=0, mem_rsp_last=0, mem_rsp_is_write=0, mem_rsp_data=0.
REQ-031 Reset SHALL take priority over a simultaneous request or beat handshake; that request is not accepted.
REQ-032 Reset mid-WAIT/BURST/WACK SHALL abandon the response without emitting further beats.
REQ-033 Reset SHALL NOT clear storage; writes already committed persist, and never-written words read as undefined.

Verification
REQ-034 Reset held for 2 cycles, then released -> mem_req_ready=1, mem_rsp_valid=0, all response outputs 0.
REQ-035 Write addr 0x0000_0040, data 0xAAAA_AAAA -> exactly 4 cycles later one beat with is_write=1, last=1, data 0xAAAA_AAAA; ready=1 the cycle after the beat.
REQ-036 Write words 0x0000_0840+4k with data 0xB000_0000+k for k=0..15, then read 0x0000_0848 -> first beat 4 cycles after accept, 16 consecutive beats with data 0xB000_0000..0xB000_000F, last only on the 16th.
REQ-037 Repeat REQ-036 with mem_rsp_ready low for 3 cycles during beat 5 -> beat 5 data 0xB000_0004 held stable, no loss or duplication, burst spans 19 cycles.
REQ-038 Aliasing: write 0x0000_1040 with 0xCCCC_CCCC, then read 0x0000_0040 -> first beat 0xCCCC_CCCC.
REQ-039 Reset asserted during beat 8 of a burst -> mem_rsp_valid=0 next cycle, mem_req_ready=1; a re-read of the same line returns unchanged data.

Source files
------------

// File: rtl/main_mem_responder.sv
// ---------------------------------------------------------------------------
// main_mem_responder
//   Behavioural main-memory model that serves a cache. It accepts single-word
//   writes and line reads. Each response starts a fixed LATENCY cycles after
//   the request is accepted. A read returns a LINE_WORDS-beat burst with
//   valid/ready handshaking. A write returns a one-beat acknowledge that echoes
//   the write data. Only one request is outstanding at a time.
//
// Ports
//   clk              in   single clock, rising edge
//   reset            in   synchronous, active-high; does not clear storage
//   mem_req_valid    in   request present
//   mem_req_ready    out  1 only when idle
//   mem_req_write    in   1 = single-word write, 0 = line read
//   mem_req_addr     in   byte address; word index = addr[log2(MEM_WORDS)+1:2]
//   mem_req_wdata    in   write data
//   mem_rsp_valid    out  response beat present
//   mem_rsp_ready    in   beat accepted this cycle
//   mem_rsp_data     out  read word or echoed write data, 0 when idle
//   mem_rsp_last     out  final beat of the response
//   mem_rsp_is_write out  beat is a write acknowledge
// ---------------------------------------------------------------------------
module main_mem_responder #(
   parameter int LATENCY    = 4,
   parameter int LINE_WORDS = 16,
   parameter int MEM_WORDS  = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_req_valid,
   output logic        mem_req_ready,
   input  logic        mem_req_write,
   input  logic [31:0] mem_req_addr,
   input  logic [31:0] mem_req_wdata,
   output logic        mem_rsp_valid,
   input  logic        mem_rsp_ready,
   output logic [31:0] mem_rsp_data,
   output logic        mem_rsp_last,
   output logic        mem_rsp_is_write
);

   localparam int IDX_W  = $clog2(MEM_WORDS);
   localparam int LINE_W = $clog2(LINE_WORDS);
   localparam int LN_W   = IDX_W - LINE_W;

   typedef enum logic [1:0] {IDLE, WAIT, BURST, WACK} state_t;

   state_t              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [LINE_W-1:0]   beat_q, beat_d;
   logic [LN_W-1:0]     line_q, line_d;
   logic                is_wr_q, is_wr_d;
   logic [31:0]         wdata_q, wdata_d;
   logic                valid_q, valid_d;
   logic                last_q, last_d;
   logic                is_write_q, is_write_d;

   logic [31:0]         mem [MEM_WORDS];
   logic [31:0]         rd_q;
   logic [IDX_W-1:0]    rd_addr;
   logic [IDX_W-1:0]    req_idx;
   logic                accept;
   logic                rsp_fire;

   // Address bits outside the word index are deliberately ignored (aliasing).
   logic                unused_addr_bits;
   assign unused_addr_bits = ^{mem_req_addr[31:IDX_W+2], mem_req_addr[1:0]};

   assign req_idx  = mem_req_addr[IDX_W+1:2];
   assign accept   = mem_req_valid && (state_q == IDLE);
   assign rsp_fire = valid_q && mem_rsp_ready;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      beat_d     = beat_q;
      line_d     = line_q;
      is_wr_d    = is_wr_q;
      wdata_d    = wdata_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = WAIT;
               cnt_d   = '0;
               beat_d  = '0;
               is_wr_d = mem_req_write;
               wdata_d = mem_req_wdata;
               line_d  = req_idx[IDX_W-1:LINE_W];
            end
         end
         WAIT: begin
            // WAIT occupies LATENCY cycles in total, the accept cycle's successor included.
            if (cnt_q == 4'(LATENCY - 1)) begin
               state_d = is_wr_q ? WACK : BURST;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         BURST: begin
            if (rsp_fire) begin
               if (beat_q == LINE_W'(LINE_WORDS - 1)) begin
                  state_d = IDLE;
               end else begin
                  beat_d = beat_q + 1'b1;
               end
            end
         end
         WACK: begin
            if (rsp_fire) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // The RAM read is issued one cycle ahead, using the beat that will be shown
      // next. While stalled, it re-reads the same word, so the output holds.
      rd_addr    = {line_d, beat_d};
      valid_d    = (state_d == BURST) || (state_d == WACK);
      is_write_d = (state_d == WACK);
      last_d     = (state_d == WACK) ||
                   ((state_d == BURST) && (beat_d == LINE_W'(LINE_WORDS - 1)));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         beat_q     <= '0;
         line_q     <= '0;
         is_wr_q    <= 1'b0;
         wdata_q    <= '0;
         valid_q    <= 1'b0;
         last_q     <= 1'b0;
         is_write_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         beat_q     <= beat_d;
         line_q     <= line_d;
         is_wr_q    <= is_wr_d;
         wdata_q    <= wdata_d;
         valid_q    <= valid_d;
         last_q     <= last_d;
         is_write_q <= is_write_d;
      end
   end

   // Backing store: it is not reset. A write commits on its accept edge, unless
   // reset wins that edge.
   always_ff @(posedge clk) begin
      if (!reset && accept && mem_req_write) begin
         mem[req_idx] <= mem_req_wdata;
      end
      rd_q <= mem[rd_addr];
   end

   assign mem_req_ready    = (state_q == IDLE);
   assign mem_rsp_valid    = valid_q;
   assign mem_rsp_last     = last_q;
   assign mem_rsp_is_write = is_write_q;
   assign mem_rsp_data     = (state_q == BURST) ? rd_q :
                             (state_q == WACK)  ? wdata_q : 32'h0;

endmodule
